// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 channel mux, with per-grant
// bursts of up to BURST_LEN beats and a valid/ready handshake to the consumer.
module rr_sel_arbiter #(
  parameter int BURST_LEN = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       out_last
);

  localparam logic [0:0]       IDLE       = 1'b0;
  localparam logic [0:0]       GRANT      = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BURST_LEN - 1);
  localparam logic             FIRST_LAST = (BURST_LEN == 1) ? 1'b1 : 1'b0;

  // Returns {found, index} of the first set bit searching start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [0:0]       state_r, state_s;
  logic [1:0]       sel_r, sel_s, ptr_r, ptr_s;
  logic [3:0]       gnt_r, gnt_s;
  logic             out_valid_r, out_valid_s, out_last_r, out_last_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       req_clean_s;
  logic [2:0]       pick_idle_s, pick_rel_s;
  logic             release_s;

  // Map X/Z request bits to 0 so that a floating request can never win arbitration.
  always_comb begin
    req_clean_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (req[i] == 1'b1) begin
        req_clean_s[i] = 1'b1;
      end else begin
        req_clean_s[i] = 1'b0;
      end
    end
  end

  assign pick_idle_s = rr_pick(req_clean_s, ptr_r);
  assign pick_rel_s  = rr_pick(req_clean_s, sel_r + 2'd1);
  // A channel that stops requesting gives up its grant at the handshake.
  assign release_s   = out_last_r | ~req_clean_s[sel_r];

  // Next-state computation for the arbiter FSM, the burst counter and the outputs.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    gnt_s       = gnt_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_idle_s[2]) begin
          state_s     = GRANT;
          sel_s       = pick_idle_s[1:0];
          gnt_s       = 4'b0001 << pick_idle_s[1:0];
          out_valid_s = 1'b1;
          out_last_s  = FIRST_LAST;
          cnt_s       = {CNT_W{1'b0}};
        end else begin
          gnt_s       = 4'b0000;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end
      end
      GRANT: begin
        if (out_valid_r && out_ready) begin
          if (release_s) begin
            ptr_s = sel_r + 2'd1;
            cnt_s = {CNT_W{1'b0}};
            if (pick_rel_s[2]) begin
              sel_s       = pick_rel_s[1:0];
              gnt_s       = 4'b0001 << pick_rel_s[1:0];
              out_valid_s = 1'b1;
              out_last_s  = FIRST_LAST;
            end else begin
              state_s     = IDLE;
              gnt_s       = 4'b0000;
              out_valid_s = 1'b0;
              out_last_s  = 1'b0;
            end
          end else begin
            if (cnt_r == LAST_CNT) begin
              cnt_s = cnt_r;
            end else begin
              cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            out_last_s = (cnt_s == LAST_CNT) ? 1'b1 : 1'b0;
          end
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = 4'b0000;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        cnt_s       = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sel_r       <= 2'b00;
      gnt_r       <= 4'b0000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      ptr_r       <= 2'b00;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      gnt_r       <= gnt_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
    end
  end

  assign sel       = sel_r;
  assign gnt       = gnt_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
Round-robin arbiter that produces the 2-bit select for the downstream 4:1, 2-bit-wide channel multiplexer.
- Arbitrates four request lines and registers the winner as `sel`, with a one-hot grant.
- Holds each grant for a burst of up to BURST_LEN accepted beats, then rotates priority.
- Presents a valid/ready handshake to the consumer of the multiplexed data.

Parameters:
- BURST_LEN, 2, maximum beats accepted per grant before priority rotates. Legal range is 1..15.
- CNT_W, 4, width of the internal beat counter. Must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per channel; bit i requests channel i (channel 0 = a … channel 3 = d).
- out_ready  input  1  downstream accepts the current beat.
- sel  output  2  registered select to the downstream mux (00=a, 01=b, 10=c, 11=d).
- gnt  output  4  one-hot grant; equals 1<<sel while out_valid=1, otherwise 0000.
- out_valid  output  1  sel/gnt are live and a beat is offered.
- out_last  output  1  the current beat is the final beat of this grant.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE; out_valid=0, out_last=0, gnt=0000, sel=00.
  - Rotation pointer ptr=0 and beat counter cnt=0.
  - Reset mid-burst aborts the burst immediately; the pointer returns to 0.
- States are IDLE and GRANT.
- IDLE:
  - If req!=0, choose the first set bit searching ptr, ptr+1, … mod 4 (wrap 3→0).
  - Register sel to the winner, set out_valid=1, cnt=0, and go to GRANT.
  - Latency is exactly 1 cycle from req sampled to out_valid=1.
  - If req==0, stay in IDLE with outputs at idle values; sel holds its last value.
- GRANT:
  - out_valid=1; sel, gnt and out_last are stable until a handshake (out_valid & out_ready).
  - out_last = (cnt==BURST_LEN-1).
  - With no handshake, nothing changes, even if req[sel] drops. Grants are never withdrawn.
- Handshake in GRANT:
  - The beat is released if out_last=1, or if req[sel]=0 in the handshake cycle.
  - Otherwise cnt increments and the grant is held.
- On release:
  - ptr_next = sel+1 mod 4.
  - Arbitrate the same-cycle req vector from ptr_next. The current channel may win again only if it is the sole requester.
  - If there is a winner, go back-to-back: out_valid stays 1, and the new sel/gnt and cnt=0 take effect next cycle. There are no idle bubbles.
  - If there is no winner, go to IDLE with out_valid=0 next cycle; ptr updates regardless.
- Simultaneous events:
  - New requests arriving during a burst never pre-empt it.
  - A request rising in the same cycle as a release is visible to that release arbitration.
- BURST_LEN=1: out_last is always 1 in GRANT; priority rotates every beat.
- Outputs are fully registered. sel is never X/Z after the first reset edge, even if a req bit is X/Z.
  - Undefined req bits are treated as 0 by the search, using an explicit 1'b1 compare per bit.
- cnt saturates at BURST_LEN-1 and never wraps.

Test Plan:
1. Reset then req=0000 for 5 cycles → out_valid=0, gnt=0000, sel=00, out_last=0 throughout.
2. req=1111, out_ready=1 constantly, BURST_LEN=2 → sel sequence 00,00,01,01,10,10,11,11,00…
   - out_last=1 on every second beat; out_valid is never 0 after the first grant.
3. req=0101 held, out_ready=0 for 4 cycles, then 1 → sel=00 and gnt=0001 are held stable while stalled.
   - After two handshakes, sel=10, gnt=0100.
4. Grant on channel 3 (req=1000); at release req=0011 → next sel=00 (wrap-around), not 01.
5. Channel 1 granted, req[1] drops on the first handshake beat → release after 1 beat, out_last was 0.
   - Next winner found from ptr=2; if req=0000, out_valid=0 the following cycle.
6. rst asserted mid-burst (cnt=1, sel=10) → next cycle out_valid=0, gnt=0000, sel=00.
   - With req=1111 afterwards, the first grant is sel=00.
